sm_serial_addsub: RTL and testbench

- Bit-serial sign-magnitude adder/subtractor.
- Sits directly upstream of the 9-bit two's-complement converter in the signed calculator datapath.
- Accepts two operands as sign + W-bit magnitude plus an add/sub select.
- Over W+2 clocks it produces a W+1-bit result magnitude and a sign bit. These drive the converter's magnitude input and negate enable respectively.

---
 rtl/sm_serial_addsub.sv | 133 +++++++++++++
 tb/tb_sm_serial_addsub.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/sm_serial_addsub.sv
// rtl/sm_serial_addsub.sv - bit-serial sign-magnitude adder/subtractor
// Produces a W+1-bit magnitude and a sign for the downstream two's-complement converter.
module sm_serial_addsub #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         op,
    input  logic         a_sign,
    input  logic [W-1:0] a_mag,
    input  logic         b_sign,
    input  logic [W-1:0] b_mag,
    output logic         busy,
    output logic         done,
    output logic         res_sign,
    output logic [W:0]   res_mag
);

    typedef enum logic [1:0] {S_IDLE, S_CMP, S_RUN, S_DONE} state_t;
    localparam int CW = $clog2(W + 1);

    state_t         state_q, state_d;
    logic [W-1:0]   a_q, a_d, b_q, b_d, acc_q, acc_d;
    logic           a_sign_q, a_sign_d, eb_sign_q, eb_sign_d;
    logic           psign_q, psign_d, sub_q, sub_d, carry_q, carry_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           res_sign_q, res_sign_d;
    logic [W:0]     res_mag_q, res_mag_d;

    logic           bit_x, bit_y, sum_bit, cout;
    logic [W:0]     fin_mag;

    always_comb begin
        state_d    = state_q;
        a_d        = a_q;
        b_d        = b_q;
        acc_d      = acc_q;
        a_sign_d   = a_sign_q;
        eb_sign_d  = eb_sign_q;
        psign_d    = psign_q;
        sub_d      = sub_q;
        carry_d    = carry_q;
        cnt_d      = cnt_q;
        res_sign_d = res_sign_q;
        res_mag_d  = res_mag_q;

        bit_x   = a_q[0];
        bit_y   = b_q[0];
        sum_bit = bit_x ^ bit_y ^ carry_q;
        cout    = sub_q ? ((~bit_x & bit_y) | (~(bit_x ^ bit_y) & carry_q))
                        : ((bit_x & bit_y) | (carry_q & (bit_x ^ bit_y)));
        // Result assembled on the last RUN bit so it is already valid while done is high.
        fin_mag = {(sub_q ? 1'b0 : cout), sum_bit, acc_q[W-1:1]};

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_d       = a_mag;
                    b_d       = b_mag;
                    a_sign_d  = a_sign;
                    eb_sign_d = b_sign ^ op;
                    state_d   = S_CMP;
                end
            end
            S_CMP: begin
                sub_d   = a_sign_q ^ eb_sign_q;
                psign_d = a_sign_q;
                if ((a_sign_q ^ eb_sign_q) && (a_q < b_q)) begin
                    a_d     = b_q;
                    b_d     = a_q;
                    psign_d = eb_sign_q;
                end
                carry_d = 1'b0;
                cnt_d   = '0;
                acc_d   = '0;
                state_d = S_RUN;
            end
            S_RUN: begin
                acc_d   = {sum_bit, acc_q[W-1:1]};
                a_d     = a_q >> 1;
                b_d     = b_q >> 1;
                carry_d = cout;
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == CW'(W - 1)) begin
                    res_mag_d  = fin_mag;
                    res_sign_d = psign_q & (|fin_mag);
                    state_d    = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            a_q        <= '0;
            b_q        <= '0;
            acc_q      <= '0;
            a_sign_q   <= 1'b0;
            eb_sign_q  <= 1'b0;
            psign_q    <= 1'b0;
            sub_q      <= 1'b0;
            carry_q    <= 1'b0;
            cnt_q      <= '0;
            res_sign_q <= 1'b0;
            res_mag_q  <= '0;
        end else begin
            state_q    <= state_d;
            a_q        <= a_d;
            b_q        <= b_d;
            acc_q      <= acc_d;
            a_sign_q   <= a_sign_d;
            eb_sign_q  <= eb_sign_d;
            psign_q    <= psign_d;
            sub_q      <= sub_d;
            carry_q    <= carry_d;
            cnt_q      <= cnt_d;
            res_sign_q <= res_sign_d;
            res_mag_q  <= res_mag_d;
        end
    end

    assign busy     = (state_q == S_CMP) || (state_q == S_RUN);
    assign done     = (state_q == S_DONE);
    assign res_sign = res_sign_q;
    assign res_mag  = res_mag_q;

endmodule

// File: tb/tb_sm_serial_addsub.sv
// tb/tb_sm_serial_addsub.sv - self-checking bench for sm_serial_addsub
module tb_sm_serial_addsub;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         start = 1'b0;
    logic         op = 1'b0;
    logic         a_sign = 1'b0;
    logic [W-1:0] a_mag = '0;
    logic         b_sign = 1'b0;
    logic [W-1:0] b_mag = '0;
    logic         busy, done, res_sign;
    logic [W:0]   res_mag;

    int n_cmp = 0;
    int n_bad = 0;

    sm_serial_addsub #(.W(W)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op),
        .a_sign(a_sign), .a_mag(a_mag), .b_sign(b_sign), .b_mag(b_mag),
        .busy(busy), .done(done), .res_sign(res_sign), .res_mag(res_mag)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic void model(input logic sa, input logic [W-1:0] ma, input logic sb,
                                  input logic [W-1:0] mb, input logic o,
                                  output logic rs, output logic [W:0] rm);
        int va, vb, r;
        va = sa ? -int'(ma) : int'(ma);
        vb = (sb ^ o) ? -int'(mb) : int'(mb);
        r  = va + vb;
        rs = (r < 0);
        rm = (r < 0) ? W'(0) + (W+1)'(-r) : (W+1)'(r);
    endfunction

    task automatic drive_random_operands();
        op     = 1'($urandom);
        a_sign = 1'($urandom);
        a_mag  = W'($urandom);
        b_sign = 1'($urandom);
        b_mag  = W'($urandom);
    endtask

    // Called at a negedge; start is sampled on the following posedge. k counts
    // negedges after that, so done is due at k = W+2 and busy for W+1 samples.
    task automatic do_op(input logic sa, input logic [W-1:0] ma, input logic sb,
                         input logic [W-1:0] mb, input logic o, input int extra_k);
        logic       exp_s;
        logic [W:0] exp_m;
        int done_k, done_cnt, busy_cnt;
        model(sa, ma, sb, mb, o, exp_s, exp_m);
        start = 1'b1; op = o; a_sign = sa; a_mag = ma; b_sign = sb; b_mag = mb;
        done_k = 0; done_cnt = 0; busy_cnt = 0;
        for (int k = 1; k <= W + 3; k++) begin
            @(negedge clk);
            if (busy) busy_cnt++;
            if (done) begin
                done_cnt++;
                if (done_k == 0) done_k = k;
                check("res_mag", 32'(res_mag), 32'(exp_m));
                check("res_sign", 32'(res_sign), 32'(exp_s));
            end
            if (k == extra_k && k < W + 3) begin
                start = 1'b1;
                drive_random_operands();
            end else begin
                start = 1'b0;
                drive_random_operands();
            end
        end
        check("done_latency", 32'(done_k), 32'(W + 2));
        check("done_count", 32'(done_cnt), 32'd1);
        check("busy_cycles", 32'(busy_cnt), 32'(W + 1));
        check("hold_mag", 32'(res_mag), 32'(exp_m));
        check("hold_sign", 32'(res_sign), 32'(exp_s));
    endtask

    initial begin
        int stray;
        int ks[5];
        ks = '{0, 1, 5, W + 1, W + 2};

        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_mag", 32'(res_mag), 32'd0);
        check("rst_sign", 32'(res_sign), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        do_op(1'b0, 8'd100, 1'b0, 8'd55,  1'b0, 0);
        do_op(1'b0, 8'd255, 1'b0, 8'd255, 1'b0, 0);
        do_op(1'b1, 8'd255, 1'b0, 8'd255, 1'b1, 0);
        do_op(1'b0, 8'd20,  1'b0, 8'd50,  1'b1, 0);
        do_op(1'b1, 8'd50,  1'b0, 8'd20,  1'b0, 0);
        do_op(1'b0, 8'd50,  1'b1, 8'd20,  1'b0, 0);
        do_op(1'b1, 8'd7,   1'b1, 8'd7,   1'b1, 0);
        do_op(1'b0, 8'd0,   1'b1, 8'd0,   1'b0, 0);
        do_op(1'b1, 8'd0,   1'b1, 8'd0,   1'b0, 0);
        do_op(1'b0, 8'd13,  1'b1, 8'd200, 1'b0, 1);
        do_op(1'b1, 8'd90,  1'b0, 8'd91,  1'b0, 5);
        do_op(1'b0, 8'd77,  1'b0, 8'd33,  1'b1, W + 2);

        // Abort mid-RUN: outputs must clear while reset is low, with no stale done.
        start = 1'b1; op = 1'b0; a_sign = 1'b0; a_mag = 8'd40; b_sign = 1'b0; b_mag = 8'd2;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            start = 1'b0;
        end
        rst = 1'b0;
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_mag", 32'(res_mag), 32'd0);
        check("abort_sign", 32'(res_sign), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        stray = 0;
        for (int k = 0; k < 2 * W; k++) begin
            @(negedge clk);
            if (done || busy) stray++;
        end
        check("abort_idle", 32'(stray), 32'd0);
        do_op(1'b1, 8'd120, 1'b1, 8'd130, 1'b0, 0);

        for (int i = 0; i < 40; i++) begin
            do_op(1'($urandom), W'($urandom), 1'($urandom), W'($urandom), 1'($urandom),
                  ks[$urandom_range(0, 4)]);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
